mme_apb_cfg: RTL

APB responder and control/status register file for the matrix-multiplication engine (MME). It decodes APB transfers from the host, holds the matrix configuration (width and the A/B/C base addresses), issues a one-cycle start pulse to the AXI datapath, and reports busy/done status. It sits between the APB port of the MME top level and the engine's control inputs.

---
 rtl/mme_apb_cfg.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/mme_apb_cfg.sv
// APB control/status register file for the matrix-multiplication engine.
// Optional error responses: define MME_APB_PSLVERR_EN.
module mme_apb_cfg #(
  parameter logic [31:0] IP_VERSION = 32'h0001_0000,
  parameter int          ADDR_W     = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              psel,
  input  logic              penable,
  input  logic [ADDR_W-1:0] paddr,
  input  logic              pwrite,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  output logic [31:0]       mat_width,
  output logic [31:0]       mat_a_addr,
  output logic [31:0]       mat_b_addr,
  output logic [31:0]       mat_c_addr,
  output logic              start,
  input  logic              done
);

  localparam logic [ADDR_W-1:0] A_VER = ADDR_W'(12'h000);
  localparam logic [ADDR_W-1:0] A_CFG = ADDR_W'(12'h100);
  localparam logic [ADDR_W-1:0] A_A   = ADDR_W'(12'h200);
  localparam logic [ADDR_W-1:0] A_B   = ADDR_W'(12'h204);
  localparam logic [ADDR_W-1:0] A_C   = ADDR_W'(12'h208);
  localparam logic [ADDR_W-1:0] A_CMD = ADDR_W'(12'h20C);
  localparam logic [ADDR_W-1:0] A_STS = ADDR_W'(12'h210);

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

  state_e      state_q;
  logic [31:0] prdata_q;
  logic        pready_q;
  logic        pslverr_q;
  logic [31:0] width_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] c_q;
  logic        start_q;
  logic        busy_q;
  logic        done_q;

  logic        hit_ver;
  logic        hit_cfg;
  logic        hit_a;
  logic        hit_b;
  logic        hit_c;
  logic        hit_cmd;
  logic        hit_sts;
  logic        access;
  logic        wr_ok;
  logic        go;
  logic [31:0] prdata_d;
  logic        pslverr_d;

  assign hit_ver = (paddr == A_VER);
  assign hit_cfg = (paddr == A_CFG);
  assign hit_a   = (paddr == A_A);
  assign hit_b   = (paddr == A_B);
  assign hit_c   = (paddr == A_C);
  assign hit_cmd = (paddr == A_CMD);
  assign hit_sts = (paddr == A_STS);

  assign access = psel & penable;
  // Config and command writes are frozen for the whole engine run.
  assign wr_ok  = pwrite & ~busy_q;
  assign go     = wr_ok & hit_cmd & pwdata[0];

  always_comb begin
    prdata_d = 32'h0;
    unique case (1'b1)
      hit_ver: prdata_d = IP_VERSION;
      hit_cfg: prdata_d = width_q;
      hit_a:   prdata_d = a_q;
      hit_b:   prdata_d = b_q;
      hit_c:   prdata_d = c_q;
      hit_sts: prdata_d = {30'h0, busy_q, done_q};
      default: prdata_d = 32'h0;
    endcase
  end

`ifdef MME_APB_PSLVERR_EN
  logic mapped;
  logic ro_wr;
  logic busy_wr;

  assign mapped  = hit_ver | hit_cfg | hit_a | hit_b |
                   hit_c | hit_cmd | hit_sts;
  assign ro_wr   = pwrite & (hit_ver | hit_sts);
  assign busy_wr = pwrite & busy_q &
                   (hit_cfg | hit_a | hit_b | hit_c | hit_cmd);
  assign pslverr_d = ~mapped | ro_wr | busy_wr;
`else
  assign pslverr_d = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      prdata_q  <= 32'h0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      width_q   <= 32'h0;
      a_q       <= 32'h0;
      b_q       <= 32'h0;
      c_q       <= 32'h0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      start_q <= 1'b0;
      if (done && busy_q) begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
      end
      unique case (state_q)
        IDLE: begin
          if (access) begin
            state_q   <= RESP;
            pready_q  <= 1'b1;
            prdata_q  <= prdata_d;
            pslverr_q <= pslverr_d;
            if (wr_ok && hit_cfg) width_q <= pwdata;
            if (wr_ok && hit_a)   a_q     <= pwdata;
            if (wr_ok && hit_b)   b_q     <= pwdata;
            if (wr_ok && hit_c)   c_q     <= pwdata;
            if (go) begin
              start_q <= 1'b1;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end
          end
        end
        RESP: begin
          state_q   <= IDLE;
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign prdata     = prdata_q;
  assign pready     = pready_q;
  assign pslverr    = pslverr_q;
  assign mat_width  = width_q;
  assign mat_a_addr = a_q;
  assign mat_b_addr = b_q;
  assign mat_c_addr = c_q;
  assign start      = start_q;

endmodule
